mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one MEM master port between the core's instr and data MEM master ports (req/gnt/valid, in-order).
//  Sits between the core wrapper and the single MEM->AXI bridge, so one bus slot serves the whole hart.
//  Tracks outstanding grants in an owner FIFO and routes each response back to the requester that issued it.
// PARAMETERS
//  LOCAL_DATA_WIDTH  32  data width of all three ports
//  LOCAL_ADDR_WIDTH  32  address width of all three ports
//  MAX_OUTSTANDING   4   owner FIFO depth (power of 2, >=2); max granted-but-unanswered transactions
// PORTS
//  clk_i                                     in   1        clock
//  rst_i                                     in   1        synchronous, active-high reset
//  instr_mem_req / data_mem_req              in   1        request from instr / data requester
//  instr_mem_addr / data_mem_addr            in   ADDR     request address
//  instr_mem_we / data_mem_we                in   1        write enable
//  instr_mem_be / data_mem_be                in   DATA/8   byte enables
//  instr_mem_wdata / data_mem_wdata          in   DATA     write data
//  instr_mem_gnt / data_mem_gnt              out  1        grant back to requester
//  instr_mem_valid / data_mem_valid          out  1        response valid to requester
//  instr_mem_rdata / data_mem_rdata          out  DATA     response data to requester
//  arb_mem_req                               out  1        downstream request
//  arb_mem_addr/we/be/wdata                  out  ADDR/1/DATA/8/DATA  muxed request fields
//  arb_mem_gnt                               in   1        downstream grant
//  arb_mem_valid                             in   1        downstream response valid
//  arb_mem_rdata                             in   DATA     downstream response data
//  arb_err_o                                 out  1        sticky: response received with owner FIFO empty
// BEHAVIOUR
//  - Reset: owner FIFO empty, lock cleared, RR pointer = instr, arb_err_o=0; all outputs 0 while rst_i=1.
//  - States: IDLE (no downstream req pending) / LOCKED (arb_mem_req=1 presented, not yet granted).
//  - IDLE: if FIFO not full and any req, select winner combinationally; arb_mem_req=1 same cycle,
//    request fields muxed from winner. arb_mem_gnt=1 same cycle -> winner's gnt=1, push owner, stay IDLE.
//    arb_mem_gnt=0 -> register winner, go LOCKED.
//  - LOCKED: selection frozen to locked owner regardless of other req (downstream sees stable req/fields);
//    on arb_mem_gnt -> gnt to owner, push owner, -> IDLE. Loser's gnt held 0.
//  - Owner FIFO full: arb_mem_req=0, both gnt=0, even if a pop occurs same cycle (no full-bypass).
//  - arb_mem_valid=1: pop head, assert that owner's valid with arb_mem_rdata, same cycle (0 latency);
//    other valid=0. Push and pop in same cycle allowed when not full; count unchanged.
//  - arb_mem_valid=1 with FIFO empty: response dropped, arb_err_o set until reset.
//  - Unselected rdata outputs driven '0. Request-to-downstream latency 0 cycles; no extra buffering.
//  - Reset mid-operation: FIFO/lock discarded; late responses hit the empty-FIFO case (dropped, flagged).
//  - FIFO pointers are clog2(MAX_OUTSTANDING) bits, wrap naturally; count is one bit wider.
// CONFIGURATION
//  MEM_PORT_ARBITER_RR_EN defined: round-robin; after each grant, pointer moves to the non-granted
//    requester, which wins the next simultaneous contention.
//  Not defined: fixed priority, data beats instr whenever both request in IDLE.
//  LOCKED behaviour, FIFO and error handling identical in both builds.
// STRUCTURE
//  - mem_arb_pkg: typedef enum logic {OWNER_INSTR, OWNER_DATA} mem_owner_e; typedef enum logic
//    {ARB_IDLE, ARB_LOCKED} arb_state_e.
//  - Sub-module mem_arb_owner_fifo: MAX_OUTSTANDING x mem_owner_e, push/pop/full/empty/head, sync reset.
//  - Top: state register, lock owner, RR pointer (ifdef), request mux, response demux, sticky error.
// TESTING
//  1. Single instr read, gnt same cycle, valid 2 cycles later rdata=32'hDEAD_BEEF -> instr_mem_valid=1,
//     rdata=DEAD_BEEF; data_mem_valid=0; arb_err_o=0.
//  2. Both req same cycle, gnt immediate, fixed-priority build -> data granted first, instr next cycle;
//     RR build with 8 back-to-back contentions -> grants alternate instr/data.
//  3. Data req, arb_mem_gnt low 3 cycles while instr req rises -> arb_mem_addr stays data addr all 4
//     cycles; only data_mem_gnt pulses; instr granted next.
//  4. MAX_OUTSTANDING=4, 4 grants, no valid -> 5th req: arb_mem_req=0; one valid -> next cycle req passes.
//  5. Interleaved grants I,D,I then 3 valids (A,B,C) -> valids routed instr=A, data=B, instr=C in order.
//  6. rst_i mid-flight with 2 outstanding, then arb_mem_valid=1 -> no requester valid, arb_err_o=1 sticky.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instr/data MEM port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } mem_owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic mem_owner_e other_owner(input mem_owner_e o);
    return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order FIFO of request owners; one entry per granted-but-unanswered transaction.
module mem_arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  mem_owner_e push_owner_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output mem_owner_e head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_owner_e        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_owner_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream MEM port between instr and data requesters; responses routed in order.
// Define MEM_PORT_ARBITER_RR_EN for round-robin contention; default is data-over-instr priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOCAL_DATA_WIDTH = 32,
  parameter int unsigned LOCAL_ADDR_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          instr_mem_req,
  input  logic [LOCAL_ADDR_WIDTH-1:0]   instr_mem_addr,
  input  logic                          instr_mem_we,
  input  logic [LOCAL_DATA_WIDTH/8-1:0] instr_mem_be,
  input  logic [LOCAL_DATA_WIDTH-1:0]   instr_mem_wdata,
  output logic                          instr_mem_gnt,
  output logic                          instr_mem_valid,
  output logic [LOCAL_DATA_WIDTH-1:0]   instr_mem_rdata,
  input  logic                          data_mem_req,
  input  logic [LOCAL_ADDR_WIDTH-1:0]   data_mem_addr,
  input  logic                          data_mem_we,
  input  logic [LOCAL_DATA_WIDTH/8-1:0] data_mem_be,
  input  logic [LOCAL_DATA_WIDTH-1:0]   data_mem_wdata,
  output logic                          data_mem_gnt,
  output logic                          data_mem_valid,
  output logic [LOCAL_DATA_WIDTH-1:0]   data_mem_rdata,
  output logic                          arb_mem_req,
  output logic [LOCAL_ADDR_WIDTH-1:0]   arb_mem_addr,
  output logic                          arb_mem_we,
  output logic [LOCAL_DATA_WIDTH/8-1:0] arb_mem_be,
  output logic [LOCAL_DATA_WIDTH-1:0]   arb_mem_wdata,
  input  logic                          arb_mem_gnt,
  input  logic                          arb_mem_valid,
  input  logic [LOCAL_DATA_WIDTH-1:0]   arb_mem_rdata,
  output logic                          arb_err_o
);

  arb_state_e state_q;
  mem_owner_e lock_owner_q;
  mem_owner_e sel_owner;
  mem_owner_e prio_owner;
  mem_owner_e head_owner;
  logic       err_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

`ifdef MEM_PORT_ARBITER_RR_EN
  mem_owner_e rr_q;
  assign prio_owner = rr_q;
`else
  assign prio_owner = OWNER_DATA;
`endif

  // Once presented downstream, the selection stays frozen until granted.
  always_comb begin
    sel_owner = lock_owner_q;
    if (state_q == ARB_IDLE) begin
      if (instr_mem_req && data_mem_req) sel_owner = prio_owner;
      else if (data_mem_req)             sel_owner = OWNER_DATA;
      else                               sel_owner = OWNER_INSTR;
    end
  end

  assign arb_mem_req = !rst_i && !fifo_full &&
                       ((state_q == ARB_LOCKED) || instr_mem_req || data_mem_req);
  assign push          = arb_mem_req && arb_mem_gnt;
  assign instr_mem_gnt = push && (sel_owner == OWNER_INSTR);
  assign data_mem_gnt  = push && (sel_owner == OWNER_DATA);

  always_comb begin
    arb_mem_addr  = '0;
    arb_mem_we    = 1'b0;
    arb_mem_be    = '0;
    arb_mem_wdata = '0;
    if (arb_mem_req) begin
      if (sel_owner == OWNER_DATA) begin
        arb_mem_addr  = data_mem_addr;
        arb_mem_we    = data_mem_we;
        arb_mem_be    = data_mem_be;
        arb_mem_wdata = data_mem_wdata;
      end else begin
        arb_mem_addr  = instr_mem_addr;
        arb_mem_we    = instr_mem_we;
        arb_mem_be    = instr_mem_be;
        arb_mem_wdata = instr_mem_wdata;
      end
    end
  end

  assign pop             = !rst_i && arb_mem_valid && !fifo_empty;
  assign instr_mem_valid = pop && (head_owner == OWNER_INSTR);
  assign data_mem_valid  = pop && (head_owner == OWNER_DATA);
  assign instr_mem_rdata = instr_mem_valid ? arb_mem_rdata : '0;
  assign data_mem_rdata  = data_mem_valid  ? arb_mem_rdata : '0;
  assign arb_err_o       = err_q && !rst_i;

  mem_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_owner_i (sel_owner),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head_owner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      lock_owner_q <= OWNER_INSTR;
      err_q        <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
      rr_q         <= OWNER_INSTR;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (arb_mem_req && !arb_mem_gnt) begin
            state_q      <= ARB_LOCKED;
            lock_owner_q <= sel_owner;
          end
        end
        ARB_LOCKED: begin
          if (push) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (arb_mem_valid && fifo_empty) err_q <= 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
      if (push) rr_q <= other_owner(sel_owner);
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; follows MEM_PORT_ARBITER_RR_EN like the design.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_mem_req, data_mem_req;
  logic [31:0] instr_mem_addr, data_mem_addr;
  logic        instr_mem_we, data_mem_we;
  logic [3:0]  instr_mem_be, data_mem_be;
  logic [31:0] instr_mem_wdata, data_mem_wdata;
  logic        instr_mem_gnt, data_mem_gnt;
  logic        instr_mem_valid, data_mem_valid;
  logic [31:0] instr_mem_rdata, data_mem_rdata;
  logic        arb_mem_req, arb_mem_we, arb_mem_gnt, arb_mem_valid;
  logic [31:0] arb_mem_addr, arb_mem_wdata, arb_mem_rdata;
  logic [3:0]  arb_mem_be;
  logic        arb_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit own_q[$];   // expected owner of each outstanding grant: 0=instr, 1=data
  bit rr_m  = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .LOCAL_DATA_WIDTH (32),
    .LOCAL_ADDR_WIDTH (32),
    .MAX_OUTSTANDING  (4)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .instr_mem_req (instr_mem_req), .instr_mem_addr (instr_mem_addr),
    .instr_mem_we (instr_mem_we), .instr_mem_be (instr_mem_be),
    .instr_mem_wdata (instr_mem_wdata), .instr_mem_gnt (instr_mem_gnt),
    .instr_mem_valid (instr_mem_valid), .instr_mem_rdata (instr_mem_rdata),
    .data_mem_req (data_mem_req), .data_mem_addr (data_mem_addr),
    .data_mem_we (data_mem_we), .data_mem_be (data_mem_be),
    .data_mem_wdata (data_mem_wdata), .data_mem_gnt (data_mem_gnt),
    .data_mem_valid (data_mem_valid), .data_mem_rdata (data_mem_rdata),
    .arb_mem_req (arb_mem_req), .arb_mem_addr (arb_mem_addr),
    .arb_mem_we (arb_mem_we), .arb_mem_be (arb_mem_be),
    .arb_mem_wdata (arb_mem_wdata), .arb_mem_gnt (arb_mem_gnt),
    .arb_mem_valid (arb_mem_valid), .arb_mem_rdata (arb_mem_rdata),
    .arb_err_o (arb_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    instr_mem_req = 0; instr_mem_addr = '0; instr_mem_we = 0; instr_mem_be = 4'hF; instr_mem_wdata = '0;
    data_mem_req  = 0; data_mem_addr  = '0; data_mem_we  = 0; data_mem_be  = 4'hF; data_mem_wdata  = '0;
    arb_mem_gnt = 0; arb_mem_valid = 0; arb_mem_rdata = '0;
  endtask

  function automatic bit contention_winner();
`ifdef MEM_PORT_ARBITER_RR_EN
    return rr_m;
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_grant(input bit o);
    own_q.push_back(o);
    rr_m = ~o;
  endtask

  // Drives one downstream response and checks it lands on the expected requester.
  task automatic respond(input logic [31:0] rd);
    bit o;
    arb_mem_valid = 1; arb_mem_rdata = rd;
    #3;
    n_cmp++;
    if (own_q.size() == 0) begin
      n_bad++; $display("FAIL respond_scoreboard_empty rdata=%h", rd);
    end else begin
      o = own_q.pop_front();
      if ({instr_mem_valid, data_mem_valid} !== {~o, o}) begin
        n_bad++; $display("FAIL resp_valid got i=%b d=%b want i=%b d=%b", instr_mem_valid, data_mem_valid, ~o, o);
      end
      n_cmp++;
      if (instr_mem_rdata !== (o ? 32'h0 : rd) || data_mem_rdata !== (o ? rd : 32'h0)) begin
        n_bad++; $display("FAIL resp_rdata got i=%h d=%h want i=%h d=%h", instr_mem_rdata, data_mem_rdata,
                          o ? 32'h0 : rd, o ? rd : 32'h0);
      end
    end
    tick();
    arb_mem_valid = 0; arb_mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1; instr_mem_req = 1; arb_mem_gnt = 1; arb_mem_valid = 1;
    #3;
    n_cmp++;
    if ({arb_mem_req, instr_mem_gnt, instr_mem_valid, data_mem_valid, arb_err_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 00000",
                        {arb_mem_req, instr_mem_gnt, instr_mem_valid, data_mem_valid, arb_err_o});
    end
    tick();
    n_cmp++;
    if (arb_mem_addr !== 32'h0 || arb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_fields got addr=%h err=%b want 0/0", arb_mem_addr, arb_err_o);
    end
    rst_i = 0; idle_inputs();
    tick();
    #3;
    n_cmp++;
    if (arb_mem_req !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle got req=%b want 0", arb_mem_req);
    end
    tick();
  endtask

  task automatic test_single_read();
    instr_mem_req = 1; instr_mem_addr = 32'h100; arb_mem_gnt = 1;
    #3;
    n_cmp++;
    if ({arb_mem_req, instr_mem_gnt, data_mem_gnt} !== 3'b110 || arb_mem_addr !== 32'h100) begin
      n_bad++; $display("FAIL single_grant got req/ig/dg=%b addr=%h want 110 addr=00000100",
                        {arb_mem_req, instr_mem_gnt, data_mem_gnt}, arb_mem_addr);
    end
    note_grant(0);
    tick(); idle_inputs();
    tick();
    respond(32'hDEAD_BEEF);
    #3;
    n_cmp++;
    if (arb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL single_err got %b want 0", arb_err_o);
    end
    tick();
  endtask

  task automatic test_contention();
    bit w;
    instr_mem_req = 1; instr_mem_addr = 32'h400;
    data_mem_req  = 1; data_mem_addr  = 32'h500; data_mem_we = 1; data_mem_wdata = 32'h55;
    arb_mem_gnt = 1;
    w = contention_winner();
    #3;
    n_cmp++;
    if ({instr_mem_gnt, data_mem_gnt} !== {~w, w} || arb_mem_addr !== (w ? 32'h500 : 32'h400) ||
        arb_mem_we !== w) begin
      n_bad++; $display("FAIL contention_first got ig=%b dg=%b addr=%h we=%b want ig=%b dg=%b",
                        instr_mem_gnt, data_mem_gnt, arb_mem_addr, arb_mem_we, ~w, w);
    end
    note_grant(w);
    tick();
    if (w) data_mem_req = 0; else instr_mem_req = 0;
    #3;
    n_cmp++;
    if ({instr_mem_gnt, data_mem_gnt} !== {w, ~w}) begin
      n_bad++; $display("FAIL contention_second got ig=%b dg=%b want ig=%b dg=%b",
                        instr_mem_gnt, data_mem_gnt, w, ~w);
    end
    note_grant(~w);
    tick(); idle_inputs();
    respond(32'h11);
    respond(32'h22);
  endtask

  task automatic test_back_to_back();
    bit w, o;
    instr_mem_req = 1; instr_mem_addr = 32'hA00;
    data_mem_req  = 1; data_mem_addr  = 32'hB00;
    arb_mem_gnt = 1;
    for (int k = 0; k < 8; k++) begin
      w = contention_winner();
      arb_mem_valid = (k > 0);
      arb_mem_rdata = 32'h1000 + 32'(k);
      #3;
      n_cmp++;
      if ({instr_mem_gnt, data_mem_gnt} !== {~w, w}) begin
        n_bad++; $display("FAIL b2b_grant[%0d] got ig=%b dg=%b want ig=%b dg=%b",
                          k, instr_mem_gnt, data_mem_gnt, ~w, w);
      end
      if (k > 0) begin
        o = own_q.pop_front();
        n_cmp++;
        if ({instr_mem_valid, data_mem_valid} !== {~o, o} ||
            (o ? data_mem_rdata : instr_mem_rdata) !== arb_mem_rdata) begin
          n_bad++; $display("FAIL b2b_resp[%0d] got iv=%b dv=%b ir=%h dr=%h want iv=%b dv=%b data=%h",
                            k, instr_mem_valid, data_mem_valid, instr_mem_rdata, data_mem_rdata,
                            ~o, o, 32'h1000 + 32'(k));
        end
      end
      note_grant(w);
      tick();
    end
    idle_inputs();
    respond(32'h1008);
  endtask

  task automatic test_lock();
    bit first;
    for (int f = 0; f < 2; f++) begin
      first = (f == 0);
      if (first) begin data_mem_req = 1; data_mem_addr = 32'h200; end
      else begin instr_mem_req = 1; instr_mem_addr = 32'h300; end
      for (int c = 0; c < 4; c++) begin
        if (c >= 1) begin
          if (first) begin instr_mem_req = 1; instr_mem_addr = 32'h300; end
          else begin data_mem_req = 1; data_mem_addr = 32'h200; end
        end
        arb_mem_gnt = (c == 3);
        #3;
        n_cmp++;
        if (arb_mem_req !== 1'b1 || arb_mem_addr !== (first ? 32'h200 : 32'h300) ||
            {instr_mem_gnt, data_mem_gnt} !== ((c == 3) ? {~first, first} : 2'b00)) begin
          n_bad++; $display("FAIL lock[%0d][%0d] got req=%b addr=%h ig=%b dg=%b", f, c,
                            arb_mem_req, arb_mem_addr, instr_mem_gnt, data_mem_gnt);
        end
        tick();
      end
      note_grant(first);
      if (first) data_mem_req = 0; else instr_mem_req = 0;
      arb_mem_gnt = 1;
      #3;
      n_cmp++;
      if ({instr_mem_gnt, data_mem_gnt} !== {first, ~first} ||
          arb_mem_addr !== (first ? 32'h300 : 32'h200)) begin
        n_bad++; $display("FAIL lock_next[%0d] got ig=%b dg=%b addr=%h", f,
                          instr_mem_gnt, data_mem_gnt, arb_mem_addr);
      end
      note_grant(~first);
      tick(); idle_inputs();
      respond(32'h3000 + 32'(f));
      respond(32'h4000 + 32'(f));
    end
  endtask

  task automatic test_full();
    bit o;
    instr_mem_req = 1; instr_mem_addr = 32'h600; arb_mem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      #3;
      n_cmp++;
      if (instr_mem_gnt !== 1'b1) begin
        n_bad++; $display("FAIL fill_grant[%0d] got %b want 1", k, instr_mem_gnt);
      end
      note_grant(0);
      tick();
    end
    arb_mem_valid = 1; arb_mem_rdata = 32'hF0;
    #3;
    n_cmp++;
    if ({arb_mem_req, instr_mem_gnt, data_mem_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL full_block got req/ig/dg=%b want 000", {arb_mem_req, instr_mem_gnt, data_mem_gnt});
    end
    o = own_q.pop_front();
    n_cmp++;
    if (instr_mem_valid !== ~o || instr_mem_rdata !== 32'hF0) begin
      n_bad++; $display("FAIL full_pop got iv=%b ir=%h want iv=1 ir=000000f0", instr_mem_valid, instr_mem_rdata);
    end
    tick();
    arb_mem_valid = 0; arb_mem_rdata = '0;
    #3;
    n_cmp++;
    if (arb_mem_req !== 1'b1 || instr_mem_gnt !== 1'b1) begin
      n_bad++; $display("FAIL after_pop got req=%b ig=%b want 1/1", arb_mem_req, instr_mem_gnt);
    end
    note_grant(0);
    tick(); idle_inputs();
    for (int k = 0; k < 4; k++) respond(32'h700 + 32'(k));
  endtask

  task automatic test_interleave();
    bit seq [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      if (seq[k]) begin data_mem_req = 1; data_mem_addr = 32'h800 + 32'(k); end
      else begin instr_mem_req = 1; instr_mem_addr = 32'h900 + 32'(k); end
      arb_mem_gnt = 1;
      #3;
      n_cmp++;
      if ({instr_mem_gnt, data_mem_gnt} !== {~seq[k], seq[k]}) begin
        n_bad++; $display("FAIL interleave_grant[%0d] got ig=%b dg=%b", k, instr_mem_gnt, data_mem_gnt);
      end
      note_grant(seq[k]);
      tick();
    end
    idle_inputs();
    tick();
    respond(32'hAAAA_0001);
    respond(32'hBBBB_0002);
    respond(32'hCCCC_0003);
  endtask

  task automatic test_reset_midflight();
    instr_mem_req = 1; instr_mem_addr = 32'hC00; arb_mem_gnt = 1;
    tick();
    instr_mem_req = 0; data_mem_req = 1; data_mem_addr = 32'hD00;
    tick();
    idle_inputs();
    rst_i = 1;
    tick();
    rst_i = 0;
    own_q.delete();
    #3;
    n_cmp++;
    if (arb_err_o !== 1'b0) begin
      n_bad++; $display("FAIL midreset_err_clear got %b want 0", arb_err_o);
    end
    tick();
    arb_mem_valid = 1; arb_mem_rdata = 32'hBAD0;
    #3;
    n_cmp++;
    if ({instr_mem_valid, data_mem_valid} !== 2'b00 || instr_mem_rdata !== 32'h0 || data_mem_rdata !== 32'h0) begin
      n_bad++; $display("FAIL late_resp_dropped got iv=%b dv=%b ir=%h dr=%h want 0 0 0 0",
                        instr_mem_valid, data_mem_valid, instr_mem_rdata, data_mem_rdata);
    end
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #3;
      n_cmp++;
      if (arb_err_o !== 1'b1) begin
        n_bad++; $display("FAIL err_sticky[%0d] got %b want 1", k, arb_err_o);
      end
      tick();
    end
    instr_mem_req = 1; instr_mem_addr = 32'hE00; arb_mem_gnt = 1;
    #3;
    n_cmp++;
    if (arb_mem_req !== 1'b1 || instr_mem_gnt !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_req got req=%b ig=%b want 1/1", arb_mem_req, instr_mem_gnt);
    end
    note_grant(0);
    tick(); idle_inputs();
    respond(32'h5A5A_5A5A);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_lock();
    test_full();
    test_interleave();
    test_reset_midflight();
    n_cmp++;
    if (own_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", own_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
